ssp_clk_div: RTL and testbench
==============================

SSP_CLK_DIV -- requirements
Module: ssp_clk_div

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the half-period divisor.
REQ-002 SHALL have parameter RESET_DIV, default 0, divisor loaded at reset (0 = divide-by-2).
REQ-003 SHALL have port PCLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port CLEAR_B  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port EN  input  1  level; 1 = generate SSPCLK, 0 = stop at idle level.
REQ-006 SHALL have port CPOL  input  1  idle level of SSPCLK.
REQ-007 SHALL have port DIV_IN  input  DIV_W  new half-period divisor value.
REQ-008 SHALL have port DIV_LD  input  1  single-cycle strobe capturing DIV_IN.
REQ-009 SHALL have port SSPCLK  output  1  divided clock, registered, glitch-free.
REQ-010 SHALL have port SSPCLK_RISE  output  1  one-cycle strobe, first PCLK cycle with SSPCLK newly high.
REQ-011 SHALL have port SSPCLK_FALL  output  1  one-cycle strobe, first PCLK cycle with SSPCLK newly low.
REQ-012 SHALL have port RUNNING  output  1  1 while the divider is active.
REQ-013 SHALL have port BUSY  output  1  1 while a loaded divisor is pending, not yet applied.

Function
REQ-014 SHALL hold active divisor div_q, shadow divisor div_s, pending flag, half-period counter cnt (DIV_W bits), run flag.
REQ-015 While running, cnt SHALL increment each cycle; at cnt==div_q, cnt SHALL return to 0 and SSPCLK SHALL toggle.
REQ-016 Half period SHALL be div_q+1 PCLK cycles; full period 2*(div_q+1); div_q=all-ones gives 2^(DIV_W+1) cycles, no overflow.
REQ-017 SSPCLK_RISE/SSPCLK_FALL SHALL be registered together with SSPCLK and assert only for toggles made while running.
REQ-018 While stopped, SSPCLK SHALL follow CPOL one cycle later, with no strobes; CPOL SHALL be ignored while running.
REQ-019 EN=1 while stopped: next cycle run=1, cnt=0, SSPCLK at idle; first toggle (away from idle) after div_q+1 cycles of running.
REQ-020 EN=0 while running with SSPCLK==CPOL: stop next cycle, cnt cleared, no further toggle.
REQ-021 EN=0 while running with SSPCLK!=CPOL: complete the half period; stop in the cycle the toggle back to idle is registered; no truncated pulse.
REQ-022 EN re-asserted before the stop completes SHALL cancel the stop; counting continues unchanged.
REQ-023 DIV_LD=1 SHALL capture DIV_IN into div_s and set pending; a later DIV_LD before application overwrites div_s.
REQ-024 Pending divisor SHALL apply: while stopped, the cycle after capture; while running, at the toggle that returns SSPCLK to idle (period boundary), with cnt restarting at 0.
REQ-025 DIV_LD coincident with an application boundary SHALL capture the new value and keep pending=1; application occurs at the next boundary.
REQ-026 BUSY SHALL equal pending; RUNNING SHALL equal the run flag.
REQ-027 With EN=1, CPOL=0, no loads, RESET_DIV=0, SSPCLK SHALL be a divide-by-2 of PCLK starting low.

Reset
REQ-028 CLEAR_B=0 at a PCLK edge SHALL set SSPCLK=0, strobes=0, RUNNING=0, BUSY=0, cnt=0, div_q=RESET_DIV, div_s=RESET_DIV, overriding all other inputs.
REQ-029 Reset asserted mid-period SHALL abort immediately; no completion of the half period.
REQ-030 After CLEAR_B returns high, the first cycle SHALL behave as stopped (REQ-018, REQ-019).

Verification
REQ-031 Reset, EN=1, CPOL=0, defaults -> SSPCLK 0,1,0,1... from 2nd cycle after EN; RISE every 2 cycles.
REQ-032 DIV_LD with DIV_IN=3 while stopped, EN=1 -> 4 cycles low, 4 high, period 8; BUSY high exactly 1 cycle.
REQ-033 Running div_q=3, DIV_LD DIV_IN=1 mid high half -> current period completes at 8 cycles, then period 4; BUSY high until the boundary.
REQ-034 div_q=4, EN dropped 2 cycles into high half -> high lasts full 5 cycles, one FALL, RUNNING low, SSPCLK stays 0.
REQ-035 CPOL=1 stopped, EN=1, div_q=1 -> SSPCLK idles 1, first FALL after 2 cycles; stop returns SSPCLK to 1.
REQ-036 CLEAR_B=0 one cycle mid-high half, div_q=5 -> next cycle SSPCLK=0, RUNNING=0, div_q=RESET_DIV, no strobes.

Source files
------------

// File: rtl/ssp_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : ssp_clk_div
//  Purpose  : Programmable SSP serial-clock divider. Produces a registered,
//             glitch-free SSPCLK from PCLK with a half period of (div+1) PCLK
//             cycles, plus single-cycle rise/fall strobes aligned to SSPCLK.
//             Divisor updates are double-buffered and only take effect while
//             stopped or at a period boundary, so no runt pulse is produced.
//  Ports    : PCLK         in   sole clock, rising edge
//             CLEAR_B      in   synchronous active-low reset
//             EN           in   1 = run, 0 = stop at idle level
//             CPOL         in   idle level of SSPCLK (sampled while stopped)
//             DIV_IN       in   new half-period divisor
//             DIV_LD       in   one-cycle strobe capturing DIV_IN
//             SSPCLK       out  divided clock
//             SSPCLK_RISE  out  first PCLK cycle with SSPCLK newly high
//             SSPCLK_FALL  out  first PCLK cycle with SSPCLK newly low
//             RUNNING      out  divider active
//             BUSY         out  loaded divisor not yet applied
//  Revision : 1.0  initial release
// ============================================================================
module ssp_clk_div #(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 0
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             EN,
  input  logic             CPOL,
  input  logic [DIV_W-1:0] DIV_IN,
  input  logic             DIV_LD,
  output logic             SSPCLK,
  output logic             SSPCLK_RISE,
  output logic             SSPCLK_FALL,
  output logic             RUNNING,
  output logic             BUSY
);

  localparam logic [DIV_W-1:0] C_RESET_DIV = DIV_W'(RESET_DIV);

  logic             run_q,  run_d;
  logic [DIV_W-1:0] cnt_q,  cnt_d;
  logic [DIV_W-1:0] div_q,  div_d;
  logic [DIV_W-1:0] divs_q, divs_d;
  logic             pend_q, pend_d;
  logic             clk_q,  clk_d;
  logic             pol_q,  pol_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             w_wrap;

  // Counter compare; equality (not overflow) keeps all-ones divisors safe.
  assign w_wrap = (cnt_q == div_q);

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    divs_d = divs_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    pol_d  = pol_q;
    rise_d = 1'b0;
    fall_d = 1'b0;

    if (!run_q) begin
      // Stopped: track idle level, hold counter cleared.
      clk_d = CPOL;
      pol_d = CPOL;
      cnt_d = '0;
      if (EN) begin
        run_d = 1'b1;
      end
      // A load landing this same cycle supersedes the pending value and
      // defers application by one cycle.
      if (pend_q && !DIV_LD) begin
        div_d  = divs_q;
        pend_d = 1'b0;
      end
    end else begin
      // pol_q (latched at start) is the idle reference while running, so
      // CPOL changes mid-run have no effect.
      if (!EN && (clk_q == pol_q)) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else if (w_wrap) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        rise_d = ~clk_q;
        fall_d = clk_q;
        // Toggle back to idle marks the period boundary: the only point
        // where a stop may complete or a new divisor may take effect.
        if (clk_q != pol_q) begin
          if (!EN) begin
            run_d = 1'b0;
          end
          if (pend_q && !DIV_LD) begin
            div_d  = divs_q;
            pend_d = 1'b0;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (DIV_LD) begin
      divs_d = DIV_IN;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      div_q  <= C_RESET_DIV;
      divs_q <= C_RESET_DIV;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      pol_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      divs_q <= divs_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      pol_q  <= pol_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign SSPCLK      = clk_q;
  assign SSPCLK_RISE = rise_q;
  assign SSPCLK_FALL = fall_q;
  assign RUNNING     = run_q;
  assign BUSY        = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_ssp_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssp_clk_div
//  Purpose  : Directed self-checking bench for ssp_clk_div. Each cycle the
//             packed output word {SSPCLK,RISE,FALL,RUNNING,BUSY} is compared
//             against a hand-computed value.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ssp_clk_div;

  logic       PCLK = 1'b0;
  logic       CLEAR_B;
  logic       EN;
  logic       CPOL;
  logic [7:0] DIV_IN;
  logic       DIV_LD;
  logic       SSPCLK;
  logic       SSPCLK_RISE;
  logic       SSPCLK_FALL;
  logic       RUNNING;
  logic       BUSY;

  int n_vec = 0;
  int n_err = 0;

  ssp_clk_div #(.DIV_W(8), .RESET_DIV(0)) dut (
    .PCLK        (PCLK),
    .CLEAR_B     (CLEAR_B),
    .EN          (EN),
    .CPOL        (CPOL),
    .DIV_IN      (DIV_IN),
    .DIV_LD      (DIV_LD),
    .SSPCLK      (SSPCLK),
    .SSPCLK_RISE (SSPCLK_RISE),
    .SSPCLK_FALL (SSPCLK_FALL),
    .RUNNING     (RUNNING),
    .BUSY        (BUSY)
  );

  always #5 PCLK = ~PCLK;

  // Advance one PCLK edge, then compare {clk,rise,fall,run,busy}.
  task automatic cyc(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    @(posedge PCLK);
    #1;
    obs = {SSPCLK, SSPCLK_RISE, SSPCLK_FALL, RUNNING, BUSY};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed clk/rise/fall/run/busy=%b required %b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    CLEAR_B = 1'b0;
    EN      = 1'b0;
    CPOL    = 1'b0;
    DIV_IN  = 8'd0;
    DIV_LD  = 1'b0;

    // Reset, including inputs that must be overridden.
    cyc("reset0", 5'b00000);
    EN = 1'b1; DIV_LD = 1'b1; DIV_IN = 8'd7; CPOL = 1'b1;
    cyc("reset1", 5'b00000);
    EN = 1'b0; DIV_LD = 1'b0; CPOL = 1'b0;
    CLEAR_B = 1'b1;
    cyc("idle", 5'b00000);

    // Default divide-by-2.
    EN = 1'b1;
    cyc("d2 start", 5'b00010);
    repeat (3) begin
      cyc("d2 high", 5'b11010);
      cyc("d2 low",  5'b00110);
    end
    EN = 1'b0;
    cyc("d2 stop", 5'b00000);

    // Load 3 while stopped: BUSY for exactly one cycle, then period 8.
    DIV_IN = 8'd3; DIV_LD = 1'b1;
    cyc("ld3 busy", 5'b00001);
    DIV_LD = 1'b0;
    cyc("ld3 applied", 5'b00000);
    EN = 1'b1;
    cyc("d3 start", 5'b00010);
    repeat (2) begin
      repeat (3) cyc("d3 low", 5'b00010);
      cyc("d3 rise", 5'b11010);
      repeat (3) cyc("d3 high", 5'b10010);
      cyc("d3 fall", 5'b00110);
    end

    // Load 1 mid high half: current period finishes, then period 4.
    repeat (3) cyc("d3b low", 5'b00010);
    cyc("d3b rise", 5'b11010);
    cyc("d3b high", 5'b10010);
    DIV_IN = 8'd1; DIV_LD = 1'b1;
    cyc("ld1 capture", 5'b10011);
    DIV_LD = 1'b0;
    cyc("ld1 pending", 5'b10011);
    cyc("ld1 boundary", 5'b00110);
    cyc("d1 low", 5'b00010);
    cyc("d1 rise", 5'b11010);
    cyc("d1 high", 5'b10010);
    cyc("d1 fall", 5'b00110);

    // Load 4, then drop EN two cycles into the high half.
    DIV_IN = 8'd4; DIV_LD = 1'b1;
    cyc("ld4 capture", 5'b00011);
    DIV_LD = 1'b0;
    cyc("ld4 rise", 5'b11011);
    cyc("ld4 high", 5'b10011);
    cyc("ld4 boundary", 5'b00110);
    repeat (4) cyc("d4 low", 5'b00010);
    cyc("d4 rise", 5'b11010);
    cyc("d4 high", 5'b10010);
    EN = 1'b0;
    repeat (3) cyc("d4 finish high", 5'b10010);
    cyc("d4 stop fall", 5'b00100);
    repeat (2) cyc("d4 stopped", 5'b00000);

    // CPOL=1, divisor 1; CPOL ignored mid-run; stop cancel; stop at idle 1.
    DIV_IN = 8'd1; DIV_LD = 1'b1; CPOL = 1'b1;
    cyc("p1 idle", 5'b10001);
    DIV_LD = 1'b0;
    cyc("p1 applied", 5'b10000);
    EN = 1'b1;
    cyc("p1 start", 5'b10010);
    CPOL = 1'b0;
    cyc("p1 cnt", 5'b10010);
    cyc("p1 fall", 5'b00110);
    EN = 1'b0;
    cyc("p1 stop pending", 5'b00010);
    EN = 1'b1;
    cyc("p1 cancel rise", 5'b11010);
    cyc("p1 high", 5'b10010);
    cyc("p1 fall2", 5'b00110);
    cyc("p1 low2", 5'b00010);
    EN = 1'b0; CPOL = 1'b1;
    cyc("p1 stop rise", 5'b11000);
    cyc("p1 stopped", 5'b10000);

    // Divisor 5, reset pulse mid high half.
    CPOL = 1'b0; DIV_IN = 8'd5; DIV_LD = 1'b1;
    cyc("ld5 capture", 5'b00001);
    DIV_LD = 1'b0;
    cyc("ld5 applied", 5'b00000);
    EN = 1'b1;
    cyc("d5 start", 5'b00010);
    repeat (5) cyc("d5 low", 5'b00010);
    cyc("d5 rise", 5'b11010);
    cyc("d5 high", 5'b10010);
    CLEAR_B = 1'b0;
    cyc("d5 reset", 5'b00000);
    CLEAR_B = 1'b1;
    cyc("post-reset start", 5'b00010);
    cyc("post-reset div0 rise", 5'b11010);
    cyc("post-reset div0 fall", 5'b00110);

    // Load coincident with a period boundary stays pending one more period.
    DIV_IN = 8'd2; DIV_LD = 1'b1;
    cyc("bnd ld2 rise", 5'b11011);
    DIV_IN = 8'd3;
    cyc("bnd ld3 fall", 5'b00111);
    DIV_LD = 1'b0;
    cyc("bnd still div0 rise", 5'b11011);
    cyc("bnd apply fall", 5'b00110);
    repeat (3) cyc("bnd d3 low", 5'b00010);
    cyc("bnd d3 rise", 5'b11010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
